// File: rtl/stream_demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
// The optional per-output counter is enabled with STREAM_DEMUX_1_4_COUNT_EN.
package stream_demux_pkg;

  localparam int unsigned N_OUT = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;

endpackage : stream_demux_pkg

// File: rtl/stream_demux_slot.sv
// One-word output slot: valid flop, data register and optional delivered-word counter.
// The counter exists only when STREAM_DEMUX_1_4_COUNT_EN is defined; otherwise cnt is 0.
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] cnt
);

  logic drain;

  assign drain = valid & ready;

  // A load wins over a drain, so a same-cycle drain+load keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

`ifdef STREAM_DEMUX_1_4_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Wraps naturally from all-ones to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (drain) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule : stream_demux_slot

// File: rtl/stream_demux_1_4.sv
// 1-to-4 stream demultiplexer with one independent one-word slot per output.
// Optional delivered-word counters are enabled with STREAM_DEMUX_1_4_COUNT_EN.
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT*CNT_W-1:0] out_cnt
);

  logic             accept;
  logic [N_OUT-1:0] load;

  // Only the addressed slot can stall the input; the others never block it.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    assign load[i] = accept & (in_sel == SEL_W'(i));

    stream_demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .data  (in_data),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .q     (out_data[i*WIDTH +: WIDTH]),
      .cnt   (out_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule : stream_demux_1_4

// File: tb/tb_stream_demux_1_4.sv
// Directed self-checking bench for stream_demux_1_4 (default WIDTH=4).
// Counter checks follow STREAM_DEMUX_1_4_COUNT_EN as seen by the bench build.
module tb_stream_demux_1_4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [3:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [31:0] out_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  stream_demux_1_4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 4'h0, 4'b0000);
    step();
    step();
    rst = 1'b0;
    check("reset_valid", 64'(out_valid), 64'h0);
    check("reset_data", 64'(out_data), 64'h0);
    check("reset_cnt", 64'(out_cnt), 64'h0);
    check("reset_in_ready", 64'(in_ready), 64'h1);

    // Single word into slot 2
    drive(1'b1, 2'd2, 4'hA, 4'b0000);
    check("single_in_ready", 64'(in_ready), 64'h1);
    step();
    drive(1'b0, 2'd2, 4'h3, 4'b0000);
    check("single_valid", 64'(out_valid), 64'h4);
    check("single_lane2", 64'(out_data[11:8]), 64'hA);
    check("single_full_in_ready", 64'(in_ready), 64'h0);
    step();
    check("ignored_when_invalid", 64'(out_valid), 64'h4);

    // Slot 2 full does not block slot 1
    drive(1'b1, 2'd1, 4'h5, 4'b0000);
    check("concurrent_in_ready", 64'(in_ready), 64'h1);
    step();
    check("concurrent_valid", 64'(out_valid), 64'h6);
    check("concurrent_lane1", 64'(out_data[7:4]), 64'h5);

    // Stalled input to full slot 2 must not overwrite it
    drive(1'b1, 2'd2, 4'hF, 4'b0000);
    check("stall_in_ready", 64'(in_ready), 64'h0);
    step();
    check("stall_lane2", 64'(out_data[11:8]), 64'hA);

    // Back-to-back on slot 3
    drive(1'b1, 2'd3, 4'h1, 4'b0000);
    step();
    check("b2b_fill_valid", 64'(out_valid), 64'hE);
    check("b2b_fill_lane3", 64'(out_data[15:12]), 64'h1);
    drive(1'b1, 2'd3, 4'h2, 4'b1000);
    check("b2b_in_ready", 64'(in_ready), 64'h1);
    step();
    check("b2b_valid", 64'(out_valid), 64'hE);
    check("b2b_lane3", 64'(out_data[15:12]), 64'h2);
    drive(1'b0, 2'd3, 4'h0, 4'b1000);
    step();
    check("drain3_valid", 64'(out_valid), 64'h6);

    // Slot 0 held for 5 cycles while slots 1 and 2 drain independently
    drive(1'b1, 2'd0, 4'h7, 4'b0000);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 2'(k), 4'(k + 9), 4'b0110);
      step();
      check("hold_lane0", 64'(out_data[3:0]), 64'h7);
      check("hold_valid0", 64'(out_valid[0]), 64'h1);
    end
    check("hold_others_drained", 64'(out_valid), 64'h1);
    drive(1'b0, 2'd0, 4'h0, 4'b0001);
    step();
    check("drain0_valid", 64'(out_valid), 64'h0);

    // Fill all four slots, then reset with handshakes pending
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 4'(k + 8), 4'b0000);
      step();
    end
    check("full_valid", 64'(out_valid), 64'hF);
    check("full_data", 64'(out_data), 64'hBA98);
    rst = 1'b1;
    drive(1'b1, 2'd1, 4'h6, 4'b1111);
    step();
    rst = 1'b0;
    drive(1'b0, 2'd0, 4'h0, 4'b0000);
    check("midrst_valid", 64'(out_valid), 64'h0);
    check("midrst_data", 64'(out_data), 64'h0);
    check("midrst_cnt", 64'(out_cnt), 64'h0);
    check("midrst_in_ready", 64'(in_ready), 64'h1);

    // Counter: 256 then 257 handshakes on output 1
    for (int k = 0; k < 257; k++) begin
      drive(1'b1, 2'd1, 4'(k), 4'b0000);
      step();
      drive(1'b0, 2'd0, 4'h0, 4'b0010);
      step();
      if (k == 255) begin
`ifdef STREAM_DEMUX_1_4_COUNT_EN
        check("cnt_256", 64'(out_cnt), 64'h0);
`else
        check("cnt_off_256", 64'(out_cnt), 64'h0);
`endif
      end
      if (k == 0) begin
`ifdef STREAM_DEMUX_1_4_COUNT_EN
        check("cnt_1", 64'(out_cnt), 64'h100);
`else
        check("cnt_off_1", 64'(out_cnt), 64'h0);
`endif
      end
    end
`ifdef STREAM_DEMUX_1_4_COUNT_EN
    check("cnt_257", 64'(out_cnt), 64'h100);
`else
    check("cnt_off_257", 64'(out_cnt), 64'h0);
`endif
    check("cnt_drained_valid", 64'(out_valid), 64'h0);
    check("cnt_last_lane1", 64'(out_data[7:4]), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_stream_demux_1_4
